// File: rtl/register_file_pkg.sv
// register_file_pkg: shared defaults and bank-command decode for the register file
package register_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RESTORE,
        SWAP,
        RESTORE_ERR
    } rf_cmd_e;

    // A save paired with an invalid restore still saves; the error is flagged separately
    function automatic rf_cmd_e decode_cmd(input logic save, input logic restore, input logic valid);
        return (save && restore && valid) ? SWAP :
               (restore && valid)         ? RESTORE :
               save                       ? SAVE :
               restore                    ? RESTORE_ERR : IDLE;
    endfunction

endpackage

// File: rtl/rf_entry.sv
// rf_entry: one main/shadow register pair with write, save, restore and swap
module rf_entry #(
    parameter int DATA_WIDTH = 32,
    parameter bit HARD_ZERO  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  save_i,
    input  logic                  restore_i,
    output logic [DATA_WIDTH-1:0] main_o
);

    logic [DATA_WIDTH-1:0] main_q, main_d, shadow_q, shadow_d;

    // Restore beats write; save copies the pre-edge main value, so save+restore swaps
    always_comb begin
        main_d   = HARD_ZERO ? '0 : (restore_i ? shadow_q : (wr_i ? wr_data_i : main_q));
        shadow_d = HARD_ZERO ? '0 : (save_i ? main_q : shadow_q);
    end

    // Both banks clear immediately on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q   <= '0;
            shadow_q <= '0;
        end else begin
            main_q   <= main_d;
            shadow_q <= shadow_d;
        end
    end

    assign main_o = main_q;

endmodule

// File: rtl/register_file.sv
// register_file: register bank with two read ports, bypassed write port and shadow bank
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  save,
    input  logic                  restore,
    output logic                  shadow_valid,
    output logic                  restore_err
);

    localparam int SLOTS = 2 ** ADDR_WIDTH;

    rf_cmd_e               cmd;
    logic                  do_save, do_restore, wr_hit;
    logic                  shadow_valid_q, shadow_valid_d, restore_err_q, restore_err_d;
    logic [DATA_WIDTH-1:0] regs [SLOTS];

    // Decode the bank command; restore or swap drops the concurrent write
    always_comb begin
        cmd            = decode_cmd(save, restore, shadow_valid_q);
        do_save        = cmd == SAVE || cmd == SWAP;
        do_restore     = cmd == RESTORE || cmd == SWAP;
        wr_hit         = wr_en && !do_restore && int'(wr_addr) < NUM_REGS && !(ZERO_REG && wr_addr == '0);
        shadow_valid_d = do_save ? 1'b1 : (do_restore ? 1'b0 : shadow_valid_q);
        restore_err_d  = restore && !shadow_valid_q;
    end

    // Status flags: shadow validity and the one-cycle restore error pulse
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            shadow_valid_q <= 1'b0;
            restore_err_q  <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            restore_err_q  <= restore_err_d;
        end
    end

    // Unimplemented address slots read as zero so out-of-range reads need no extra mux
    for (genvar i = 0; i < SLOTS; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_entry
            rf_entry #(
                .DATA_WIDTH(DATA_WIDTH),
                .HARD_ZERO (ZERO_REG && i == 0)
            ) u_entry (
                .clk_i    (clock),
                .rst_ni   (clear),
                .wr_i     (wr_hit && wr_addr == ADDR_WIDTH'(i)),
                .wr_data_i(wr_data),
                .save_i   (do_save),
                .restore_i(do_restore),
                .main_o   (regs[i])
            );
        end else begin : g_empty
            assign regs[i] = '0;
        end
    end

    assign rd_data_a    = (BYPASS && wr_hit && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
    assign rd_data_b    = (BYPASS && wr_hit && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
    assign shadow_valid = shadow_valid_q;
    assign restore_err  = restore_err_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table plus reset and save/restore corner sequences
module tb_register_file;

    logic        clock = 1'b0;
    logic        clear, wr_en, save, restore;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data;
    logic [31:0] a1, b1, a0, b0;
    logic        sv1, re1, sv0, re0;
    int          n_pass = 0, n_total = 0;

    always #5 clock = ~clock;

    // d1: zero register and bypass on, 16 entries
    register_file d1 (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(a1), .rd_data_b(b1),
        .save(save), .restore(restore), .shadow_valid(sv1), .restore_err(re1)
    );

    // d0: no zero register, no bypass, 12 entries so addresses 12..15 are out of range
    register_file #(.NUM_REGS(12), .ZERO_REG(1'b0), .BYPASS(1'b0)) d0 (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(a0), .rd_data_b(b0),
        .save(save), .restore(restore), .shadow_valid(sv0), .restore_err(re0)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra, rb;
        logic        sv, rs;
        logic [31:0] a1, b1, a0, b0;
        logic        esv, ere;
    } vec_t;

    vec_t v [22];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic s, input logic r);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb; save = s; restore = r;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea1, input logic [31:0] eb1,
                           input logic [31:0] ea0, input logic [31:0] eb0, input logic esv, input logic ere);
        chk({tag, " rd_a d1"}, a1, ea1);
        chk({tag, " rd_b d1"}, b1, eb1);
        chk({tag, " rd_a d0"}, a0, ea0);
        chk({tag, " rd_b d0"}, b0, eb0);
        chk({tag, " shadow_valid d1"}, 32'(sv1), 32'(esv));
        chk({tag, " shadow_valid d0"}, 32'(sv0), 32'(esv));
        chk({tag, " restore_err d1"}, 32'(re1), 32'(ere));
        chk({tag, " restore_err d0"}, 32'(re0), 32'(ere));
    endtask

    initial begin
        //        we wa  wd            ra  rb  sv rs  a1            b1            a0            b0            esv ere
        v[0]  = '{0, 0,  32'h0,        0,  15, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0};
        v[1]  = '{1, 3,  32'hDEADBEEF, 3,  3,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0};
        v[2]  = '{0, 0,  32'h0,        3,  0,  0, 0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0};
        v[3]  = '{1, 0,  32'h1234,     0,  3,  0, 0,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0};
        v[4]  = '{0, 0,  32'h0,        0,  12, 0, 0,  32'h0,        32'h0,        32'h1234,     32'h0,        0, 0};
        v[5]  = '{1, 13, 32'h55,       13, 13, 0, 0,  32'h55,       32'h55,       32'h0,        32'h0,        0, 0};
        v[6]  = '{0, 0,  32'h0,        13, 5,  0, 0,  32'h55,       32'h0,        32'h0,        32'h0,        0, 0};
        v[7]  = '{1, 5,  32'hA,        5,  3,  0, 0,  32'hA,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0};
        v[8]  = '{1, 5,  32'hB,        5,  5,  1, 0,  32'hB,        32'hB,        32'hA,        32'hA,        0, 0};
        v[9]  = '{1, 5,  32'hC,        5,  0,  0, 0,  32'hC,        32'h0,        32'hB,        32'h1234,     1, 0};
        v[10] = '{1, 3,  32'hFF,       5,  3,  0, 1,  32'hC,        32'hDEADBEEF, 32'hC,        32'hDEADBEEF, 1, 0};
        v[11] = '{0, 0,  32'h0,        5,  3,  0, 0,  32'hA,        32'hDEADBEEF, 32'hA,        32'hDEADBEEF, 0, 0};
        v[12] = '{1, 2,  32'h7,        2,  5,  0, 1,  32'h7,        32'hA,        32'h0,        32'hA,        0, 0};
        v[13] = '{0, 0,  32'h0,        2,  0,  0, 0,  32'h7,        32'h0,        32'h7,        32'h1234,     0, 1};
        v[14] = '{0, 0,  32'h0,        2,  2,  0, 0,  32'h7,        32'h7,        32'h7,        32'h7,        0, 0};
        v[15] = '{1, 1,  32'h2,        1,  1,  0, 0,  32'h2,        32'h2,        32'h0,        32'h0,        0, 0};
        v[16] = '{0, 0,  32'h0,        1,  5,  1, 0,  32'h2,        32'hA,        32'h2,        32'hA,        0, 0};
        v[17] = '{1, 1,  32'h1,        1,  2,  0, 0,  32'h1,        32'h7,        32'h2,        32'h7,        1, 0};
        v[18] = '{1, 2,  32'h99,       1,  2,  1, 1,  32'h1,        32'h7,        32'h1,        32'h7,        1, 0};
        v[19] = '{0, 0,  32'h0,        1,  2,  0, 0,  32'h2,        32'h7,        32'h2,        32'h7,        1, 0};
        v[20] = '{0, 0,  32'h0,        1,  1,  1, 1,  32'h2,        32'h2,        32'h2,        32'h2,        1, 0};
        v[21] = '{0, 0,  32'h0,        1,  1,  0, 0,  32'h1,        32'h1,        32'h1,        32'h1,        1, 0};

        clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 clear = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(v[i].we, v[i].wa, v[i].wd, v[i].ra, v[i].rb, v[i].sv, v[i].rs);
            @(negedge clock);
            chk_all($sformatf("v%0d", i), v[i].a1, v[i].b1, v[i].a0, v[i].b0, v[i].esv, v[i].ere);
            @(posedge clock);
            #1;
        end

        // Asynchronous clear in the middle of a swap request wipes every register
        drive(0, 0, 0, 1, 1, 1, 1);
        #2 clear = 1'b0;
        for (int k = 0; k < 16; k++) begin
            rd_addr_a = 4'(k);
            rd_addr_b = 4'(15 - k);
            @(negedge clock);
            chk_all($sformatf("clear r%0d", k), 0, 0, 0, 0, 0, 0);
        end
        save = 1'b0;
        restore = 1'b0;
        @(posedge clock);
        #1 clear = 1'b1;

        // Save+restore without a valid shadow acts as a save and flags an error
        drive(1, 4, 32'h44, 4, 4, 0, 0);
        @(posedge clock); #1;
        drive(1, 4, 32'h55, 4, 1, 1, 1);
        @(negedge clock);
        chk_all("sr_invalid", 32'h55, 0, 32'h44, 0, 0, 0);
        @(posedge clock); #1;
        drive(0, 0, 0, 4, 1, 0, 0);
        @(negedge clock);
        chk_all("after_sr_invalid", 32'h55, 0, 32'h55, 0, 1, 1);
        @(posedge clock); #1;
        drive(0, 0, 0, 4, 1, 0, 1);
        @(negedge clock);
        chk_all("restore_req", 32'h55, 0, 32'h55, 0, 1, 0);
        @(posedge clock); #1;
        drive(0, 0, 0, 4, 1, 0, 0);
        @(negedge clock);
        chk_all("restored", 32'h44, 0, 32'h44, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register file that generalises the single-word bus register into a bank of `NUM_REGS` general-purpose registers. It provides two combinational read ports, one write port with optional write-through bypass, an optional hard-wired zero register, and a one-cycle save/restore shadow bank for context switches. It sits between the bus/datapath and the ALU operand latches.

## Interface
- `DATA_WIDTH`, 32, width of each register.
- `NUM_REGS`, 16, number of registers; must be ≥2.
- `ADDR_WIDTH`, `$clog2(NUM_REGS)`, address width (derived; not overridden).
- `ZERO_REG`, 1, when 1, R0 reads as zero and ignores writes.
- `BYPASS`, 1, when 1, a same-cycle write to the addressed register is forwarded to the read port.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_WIDTH  write register index.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_addr_a`, `rd_addr_b`  in  ADDR_WIDTH  read indices.
- `rd_data_a`, `rd_data_b`  out  DATA_WIDTH  read data (combinational).
- `save`  in  1  copy main bank into shadow bank.
- `restore`  in  1  copy shadow bank into main bank.
- `shadow_valid`  out  1  shadow bank holds a saved context.
- `restore_err`  out  1  one-cycle pulse: restore requested with no valid shadow.

## Operation
- Reset (`clear`=0, asynchronous): all main and shadow registers are 0; `shadow_valid`=0; `restore_err`=0.
- Write: on the clock edge with `wr_en`=1, `regs[wr_addr] <= wr_data`. Writes to addresses ≥`NUM_REGS` are ignored. With `ZERO_REG`=1, writes to address 0 are ignored.
- Read: `rd_data_x = regs[rd_addr_x]`. The result is 0 if the address is ≥`NUM_REGS`, or if the address is 0 with `ZERO_REG`=1.
  - With `BYPASS`=1 and `wr_en`=1 and `wr_addr==rd_addr_x` (and that address is writable), the read port returns `wr_data`.
  - With `BYPASS`=0, it returns the pre-edge value.
- Save (`save`=1, `restore`=0): every `shadow[i] <= regs[i]`, using pre-edge values (a concurrent write is not captured). `shadow_valid <= 1`. A concurrent `wr_en` updates main normally.
- Restore (`restore`=1, `save`=0, `shadow_valid`=1): every `regs[i] <= shadow[i]`. `shadow_valid <= 0`. A concurrent `wr_en` is dropped, since restore has priority.
- Restore with `shadow_valid`=0: main bank unchanged, concurrent write proceeds, `restore_err <= 1` for one cycle.
- Save and restore together with `shadow_valid`=1: banks swap (`regs<=shadow`, `shadow<=regs`). `shadow_valid` stays 1 and the concurrent write is dropped.
- Save and restore together with `shadow_valid`=0: treated as save. `restore_err` pulses.
- With `ZERO_REG`=1, the R0 storage is held at 0 in both banks.

## Timing
- Write latency: 1 edge to storage, 0 cycles to a read port with `BYPASS`=1, 1 cycle with `BYPASS`=0.
- Save/restore complete in one edge. Data is readable from the restored bank in the next cycle.
- `restore_err` is registered: it is high for exactly the cycle after the offending edge.
- Reset assertion mid-save or mid-restore: both banks go to 0 immediately, and `shadow_valid`=0.
- No stalls and no busy signal: every command is accepted every cycle.

## Structure
- Package `register_file_pkg`:
  - default `DATA_WIDTH`/`NUM_REGS` constants;
  - `rf_cmd_e` enum {IDLE, SAVE, RESTORE, SWAP, RESTORE_ERR}, decoded from `save`/`restore`/`shadow_valid`.
- One natural sub-module, `rf_entry`: a main/shadow register pair with async active-low clear, write, save, restore and swap controls, instantiated `NUM_REGS` times via generate. Bypass and read muxing live in the top level.

## Test plan
- Reset, then read all addresses → every `rd_data`=0, `shadow_valid`=0.
- Write R3=0xDEADBEEF with `rd_addr_a`=3 in the same cycle:
  - `BYPASS`=1 → `rd_data_a`=0xDEADBEEF that cycle;
  - `BYPASS`=0 → 0 that cycle, 0xDEADBEEF the next.
- Write R0=0x1234 with `ZERO_REG`=1 → R0 reads 0. With `ZERO_REG`=0 → reads 0x1234.
- Sequence:
  - R5=0xA;
  - save together with a write of R5=0xB;
  - write R5=0xC;
  - restore → R5 reads 0xA, `shadow_valid`=0.
- Restore with `shadow_valid`=0 and a concurrent write R2=0x7 → `restore_err`=1 for exactly one cycle, R2=0x7.
- R1=0x1 in main and 0x2 in shadow, then save+restore together → R1=0x2; a second save+restore → R1=0x1, `shadow_valid`=1 throughout. Assert `clear`=0 mid-sequence → all reads 0.
